// File: rtl/digital_clock_scan_if.sv
// digital_clock_scan_if
// Groups the divider/key inputs and the time/display outputs of the
// digital clock stage.
//   clk_1hz, clk_500hz : square waves from the clock divider
//   key_mode, key_inc  : debounced active-high keys
//   hour_bcd/min_bcd/sec_bcd : BCD time of day
//   mode               : 00 RUN, 01 SET_HOUR, 10 SET_MIN
//   dig_sel, seg       : active-low digit enables and segments
// Handshake: there is no valid/ready pair. Every input is a level that the
// slave samples on every clk_50m edge; a rising edge of a level is the
// event. Every output is a registered level that is valid on every cycle.
// Modports: master drives the inputs (divider/keys/bench), slave is the
// clock block.
interface digital_clock_scan_if;
  logic       clk_1hz;
  logic       clk_500hz;
  logic       key_mode;
  logic       key_inc;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode;
  logic [5:0] dig_sel;
  logic [7:0] seg;

  modport master (
    output clk_1hz, clk_500hz, key_mode, key_inc,
    input  hour_bcd, min_bcd, sec_bcd, mode, dig_sel, seg
  );

  modport slave (
    input  clk_1hz, clk_500hz, key_mode, key_inc,
    output hour_bcd, min_bcd, sec_bcd, mode, dig_sel, seg
  );
endinterface

// File: rtl/digital_clock_scan.sv
// digital_clock_scan
// 24-hour BCD time of day with a two-key set mode and a six-digit
// multiplexed common-anode 7-segment driver. Divider outputs are sampled
// as data and edge-detected; clk_50m is the only clock.
// Ports:
//   clk_50m : 50 MHz system clock
//   rst_n   : asynchronous active-low reset
//   bus     : digital_clock_scan_if.slave (inputs clk_1hz, clk_500hz,
//             key_mode, key_inc; outputs hour_bcd, min_bcd, sec_bcd,
//             mode, dig_sel, seg)
// The mode output is the FSM state itself.
module digital_clock_scan (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  digital_clock_scan_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  // bit 0 clk_1hz, bit 1 clk_500hz, bit 2 key_mode, bit 3 key_inc
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] prev;
  logic [3:0] rise;
  logic       tick_1s;
  logic       tick_scan;
  logic       mode_p;
  logic       inc_p;

  mode_e      mode_q;
  mode_e      mode_n;
  logic [7:0] hour_q;
  logic [7:0] min_q;
  logic [7:0] sec_q;
  logic [7:0] hour_n;
  logic [7:0] min_n;
  logic [7:0] sec_n;
  logic [2:0] scan_idx;
  logic [5:0] dig_sel_q;
  logic [7:0] seg_q;

  logic [3:0] digit_val;
  logic       blank;
  logic       dp_on;

  // Wraps to 00 at 'last'; otherwise a plain two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] last);
    logic [7:0] r;
    if (v == last)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Segment code with dp off; active-low, seg[6:0] = g..a.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] r;
    case (d)
      4'd0: r = 8'hC0;
      4'd1: r = 8'hF9;
      4'd2: r = 8'hA4;
      4'd3: r = 8'hB0;
      4'd4: r = 8'h99;
      4'd5: r = 8'h92;
      4'd6: r = 8'h82;
      4'd7: r = 8'hF8;
      4'd8: r = 8'h80;
      4'd9: r = 8'h90;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  // Input conditioning: two-flop synchronizer plus previous-value flop.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b0;
      sync2 <= 4'b0;
      prev  <= 4'b0;
    end else begin
      sync1 <= {bus.key_inc, bus.key_mode, bus.clk_500hz, bus.clk_1hz};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise      = sync2 & ~prev;
  assign tick_1s   = rise[0];
  assign tick_scan = rise[1];
  assign mode_p    = rise[2];
  assign inc_p     = rise[3];

  // Mode FSM state register and time registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= RUN;
      hour_q <= 8'h00;
      min_q  <= 8'h00;
      sec_q  <= 8'h00;
    end else begin
      mode_q <= mode_n;
      hour_q <= hour_n;
      min_q  <= min_n;
      sec_q  <= sec_n;
    end
  end

  // Next state and next time. A mode press wins over an increment press in
  // the same cycle. The carry chain is resolved combinationally so all three
  // fields change on one edge.
  always_comb begin
    mode_n = mode_q;
    hour_n = hour_q;
    min_n  = min_q;
    sec_n  = sec_q;
    if (mode_p) begin
      case (mode_q)
        RUN: begin
          mode_n = SET_HOUR;
          sec_n  = 8'h00;
        end
        SET_HOUR: mode_n = SET_MIN;
        default:  mode_n = RUN;
      endcase
    end else if (inc_p && (mode_q == SET_HOUR)) begin
      hour_n = bcd_inc(hour_q, 8'h23);
    end else if (inc_p && (mode_q == SET_MIN)) begin
      min_n = bcd_inc(min_q, 8'h59);
    end else if (tick_1s && (mode_q == RUN)) begin
      sec_n = bcd_inc(sec_q, 8'h59);
      if (sec_q == 8'h59) begin
        min_n = bcd_inc(min_q, 8'h59);
        if (min_q == 8'h59)
          hour_n = bcd_inc(hour_q, 8'h23);
      end
    end
  end

  // Scan index 0..5.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)
      scan_idx <= 3'd0;
    else if (tick_scan)
      scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
  end

  always_comb begin
    digit_val = 4'd0;
    case (scan_idx)
      3'd0: digit_val = hour_q[7:4];
      3'd1: digit_val = hour_q[3:0];
      3'd2: digit_val = min_q[7:4];
      3'd3: digit_val = min_q[3:0];
      3'd4: digit_val = sec_q[7:4];
      3'd5: digit_val = sec_q[3:0];
      default: digit_val = 4'd0;
    endcase
  end

  // The field being set flashes off while the synchronized 1 Hz level is low.
  assign blank = !sync2[0] &&
                 (((mode_q == SET_HOUR) && (scan_idx <= 3'd1)) ||
                  ((mode_q == SET_MIN) && ((scan_idx == 3'd2) || (scan_idx == 3'd3))));
  // dp separates hh.mm.ss
  assign dp_on = (scan_idx == 3'd1) || (scan_idx == 3'd3);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel_q <= 6'b111111;
      seg_q     <= 8'hFF;
    end else begin
      dig_sel_q <= ~(6'b000001 << scan_idx);
      if (blank)
        seg_q <= 8'hFF;
      else if (dp_on)
        seg_q <= seg_code(digit_val) & 8'h7F;
      else
        seg_q <= seg_code(digit_val);
    end
  end

  assign bus.hour_bcd = hour_q;
  assign bus.min_bcd  = min_q;
  assign bus.sec_bcd  = sec_q;
  assign bus.mode     = mode_q;
  assign bus.dig_sel  = dig_sel_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_digital_clock_scan.sv
// tb_digital_clock_scan
// Directed bench for digital_clock_scan. Stimulus tasks push the expected
// output snapshot {hour, min, sec, mode, dig_sel, seg} with a mask into
// queues; a monitor on the falling edge pops and compares.
module tb_digital_clock_scan;

  localparam int W = 40;
  localparam logic [W-1:0] M_ALL  = {W{1'b1}};
  localparam logic [W-1:0] M_TM   = {26'h3FFFFFF, 14'h0};
  localparam logic [W-1:0] M_DISP = {26'h0, 14'h3FFF};

  localparam int P_1HZ   = 0;
  localparam int P_500HZ = 1;
  localparam int P_MODE  = 2;
  localparam int P_INC   = 3;

  logic clk_50m;
  logic rst_n;

  digital_clock_scan_if bus ();

  digital_clock_scan dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           chk_cnt  = 0;
  int           pass_cnt = 0;
  int           push_cnt = 0;
  int           err_cnt  = 0;

  always @(negedge clk_50m) begin
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] a;
    string        n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      n = name_q.pop_front();
      a = {bus.hour_bcd, bus.min_bcd, bus.sec_bcd, bus.mode, bus.dig_sel, bus.seg};
      chk_cnt++;
      if ((a & m) == (e & m))
        pass_cnt++;
      else
        $display("FAIL %s: got %h required %h (mask %h)", n, a & m, e & m, m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      P_1HZ:   bus.clk_1hz   = v;
      P_500HZ: bus.clk_500hz = v;
      P_MODE:  bus.key_mode  = v;
      default: bus.key_inc   = v;
    endcase
  endtask

  task automatic pulse(input int which, input int n);
    repeat (n) begin
      drive(which, 1'b1);
      cycles(4);
      drive(which, 1'b0);
      cycles(4);
    end
  endtask

  task automatic pulse_both();
    bus.key_mode = 1'b1;
    bus.key_inc  = 1'b1;
    cycles(4);
    bus.key_mode = 1'b0;
    bus.key_inc  = 1'b0;
    cycles(4);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] e,
                            input logic [W-1:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(name);
    push_cnt++;
    @(negedge clk_50m);
    #1;
  endtask

  function automatic logic [W-1:0] tm(input logic [7:0] h, input logic [7:0] mi,
                                      input logic [7:0] s, input logic [1:0] md);
    return {h, mi, s, md, 14'h0};
  endfunction

  function automatic logic [W-1:0] disp(input logic [5:0] ds, input logic [7:0] sg);
    return {26'h0, ds, sg};
  endfunction

  // Expected display at 12:34:56 in RUN for index 0..5.
  logic [7:0] seg_tab [6] = '{8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82};
  logic [5:0] dig_tab [6] = '{6'b111110, 6'b111101, 6'b111011,
                              6'b110111, 6'b101111, 6'b011111};

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.clk_1hz   = 1'b0;
    bus.clk_500hz = 1'b0;
    bus.key_mode  = 1'b0;
    bus.key_inc   = 1'b0;
    cycles(3);
    expect_out("reset_values", {8'h00, 8'h00, 8'h00, 2'b00, 6'b111111, 8'hFF}, M_ALL);

    @(posedge clk_50m); #1;
    rst_n = 1'b1;
    cycles(1);
    expect_out("first_edge_display", {8'h00, 8'h00, 8'h00, 2'b00, 6'b111110, 8'hC0}, M_ALL);

    pulse(P_1HZ, 1);
    expect_out("one_second", tm(8'h00, 8'h00, 8'h01, 2'b00), M_TM);
    pulse(P_1HZ, 9);
    expect_out("ten_seconds", tm(8'h00, 8'h00, 8'h10, 2'b00), M_TM);

    pulse(P_MODE, 1);
    expect_out("enter_set_hour", tm(8'h00, 8'h00, 8'h00, 2'b01), M_TM);
    pulse(P_INC, 25);
    expect_out("hour_inc_25", tm(8'h01, 8'h00, 8'h00, 2'b01), M_TM);
    pulse(P_1HZ, 2);
    expect_out("set_ignores_tick", tm(8'h01, 8'h00, 8'h00, 2'b01), M_TM);

    pulse(P_INC, 22);
    expect_out("hour_23", tm(8'h23, 8'h00, 8'h00, 2'b01), M_TM);
    pulse(P_MODE, 1);
    pulse(P_INC, 59);
    expect_out("min_59", tm(8'h23, 8'h59, 8'h00, 2'b10), M_TM);
    pulse(P_INC, 1);
    expect_out("min_wrap_no_carry", tm(8'h23, 8'h00, 8'h00, 2'b10), M_TM);
    pulse(P_INC, 59);
    pulse_both();
    expect_out("mode_wins_over_inc", tm(8'h23, 8'h59, 8'h00, 2'b00), M_TM);
    pulse(P_INC, 1);
    expect_out("inc_in_run_ignored", tm(8'h23, 8'h59, 8'h00, 2'b00), M_TM);

    pulse(P_1HZ, 58);
    expect_out("time_235958", tm(8'h23, 8'h59, 8'h58, 2'b00), M_TM);
    pulse(P_1HZ, 1);
    expect_out("time_235959", tm(8'h23, 8'h59, 8'h59, 2'b00), M_TM);
    pulse(P_1HZ, 1);
    expect_out("full_rollover", tm(8'h00, 8'h00, 8'h00, 2'b00), M_TM);

    // 12:34:56 then scan through all digits twice.
    pulse(P_MODE, 1);
    pulse(P_INC, 12);
    pulse(P_MODE, 1);
    pulse(P_INC, 34);
    pulse(P_MODE, 1);
    pulse(P_1HZ, 56);
    expect_out("time_123456", tm(8'h12, 8'h34, 8'h56, 2'b00), M_TM);
    expect_out("scan_idx0", disp(dig_tab[0], seg_tab[0]), M_DISP);
    for (int k = 0; k < 12; k++) begin
      pulse(P_500HZ, 1);
      expect_out($sformatf("scan_step%0d", k), disp(dig_tab[(k + 1) % 6], seg_tab[(k + 1) % 6]), M_DISP);
    end

    // Fresh reset, then 05:06:00 in SET_MIN with blink, then async reset.
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    pulse(P_MODE, 1);
    pulse(P_INC, 5);
    pulse(P_MODE, 1);
    pulse(P_INC, 6);
    expect_out("time_0506_set_min", tm(8'h05, 8'h06, 8'h00, 2'b10), M_TM);
    pulse(P_500HZ, 2);
    expect_out("blink_min_tens_off", disp(6'b111011, 8'hFF), M_DISP);
    bus.clk_1hz = 1'b1;
    cycles(4);
    expect_out("blink_min_tens_on", disp(6'b111011, 8'hC0), M_DISP);

    @(posedge clk_50m); #2;
    rst_n = 1'b0;
    #1;
    if ((bus.dig_sel !== 6'b111111) || (bus.seg !== 8'hFF) || (bus.mode !== 2'b00)) begin
      err_cnt++;
      $display("FAIL async_reset_immediate: got dig_sel %b seg %h mode %b required 111111 FF 00",
               bus.dig_sel, bus.seg, bus.mode);
    end
    // Compared at the next falling edge, before any rising edge.
    expect_out("async_reset", {8'h00, 8'h00, 8'h00, 2'b00, 6'b111111, 8'hFF}, M_ALL);

    repeat (4) @(negedge clk_50m);
    #1;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    if (chk_cnt != push_cnt) begin
      err_cnt++;
      $display("FAIL check_count: got %0d required %0d", chk_cnt, push_cnt);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    if ((pass_cnt == chk_cnt) && (err_cnt == 0))
      $display("PASS");
    else
      $display("FAIL %0d scoreboard mismatches, %0d direct errors", chk_cnt - pass_cnt, err_cnt);
    $finish;
  end

endmodule
